// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request at
// a time and hands fetched words to the IF/ID register.
//
// Three states:
//   FETCH : a request for pc is live on the memory port.
//   HOLD  : a word completed under stall and sits in the hold buffer; no request.
//   DRAIN : a redirect arrived while a request was still outstanding. The old
//           address stays on the bus until memory completes, and that data is
//           thrown away. pc already holds the redirect target.
//
// Optional feature: define IF_PERF_EN to build the delivered-instruction and
// memory-wait counters. Without it, perf_fetched and perf_wait are tied to zero
// and no counter flops exist.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out,
  output logic        fetch_valid,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] hold_buf;
  logic [31:0] pc_next4;
  logic [31:0] redirect_target;
  logic        done;
  logic        unused_redirect_lsbs;

  // Wraps modulo 2^32 by construction (32-bit add, carry dropped).
  assign pc_next4        = pc + 32'd4;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The request is combinational so that it drops the instant reset asserts
  // (abandoning any transfer) and is live with RESET_PC in the first cycle
  // after release. In DRAIN the bus keeps the stale address, not the new pc.
  assign imem_req  = !reset && (state != S_HOLD);
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
  assign done      = imem_req && imem_ready;

  // Fetch FSM, PC and IF/ID-facing output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      drain_addr   <= '0;
      hold_buf     <= '0;
      instr_out    <= '0;
      pc_plus4_out <= '0;
      fetch_valid  <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over stall: bubble out, discard any buffered word.
      pc          <= redirect_target;
      instr_out   <= '0;
      fetch_valid <= 1'b0;
      hold_buf    <= '0;
      case (state)
        S_FETCH: begin
          if (done) begin
            state <= S_FETCH;
          end else begin
            // Outstanding request must finish at its original address.
            state      <= S_DRAIN;
            drain_addr <= pc;
          end
        end
        S_HOLD:  state <= S_FETCH;
        S_DRAIN: state <= done ? S_FETCH : S_DRAIN;
        default: state <= S_FETCH;
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (stall) begin
            // Outputs and pc frozen; a word arriving now is parked.
            if (done) begin
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
            end
          end else if (done) begin
            instr_out    <= imem_rdata;
            pc_plus4_out <= pc_next4;
            fetch_valid  <= 1'b1;
            pc           <= pc_next4;
          end else begin
            instr_out   <= '0;
            fetch_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_out    <= hold_buf;
            pc_plus4_out <= pc_next4;
            fetch_valid  <= 1'b1;
            pc           <= pc_next4;
            state        <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // Stale data is never presented; pc already points at the target.
          if (!stall) begin
            instr_out   <= '0;
            fetch_valid <= 1'b0;
          end
          if (done) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] fetched_cnt;
  logic [31:0] wait_cnt;
  logic        deliver;

  // A new instruction reaches instr_out from the bus or from the hold buffer.
  assign deliver = !redirect_valid && !stall &&
                   (((state == S_FETCH) && done) || (state == S_HOLD));

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      if (deliver) begin
        fetched_cnt <= fetched_cnt + 32'd1;
      end
      if (imem_req && !imem_ready) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_cnt;
  assign perf_wait    = wait_cnt;
`else
  assign perf_fetched = '0;
  assign perf_wait    = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Expected deliveries are queued when the
// completing memory word is driven and popped when the stage presents it.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers pc wraparound.
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;
  logic        fetch_valid;
  logic [31:0] perf_fetched;
  logic [31:0] perf_wait;

  logic        w_stall = 1'b0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ready;
  logic [31:0] w_rdata;
  logic [31:0] w_pc4;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [31:0] w_perf_fetched;
  logic [31:0] w_perf_wait;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc_plus4_out(pc_plus4_out),
    .instr_out(instr_out), .fetch_valid(fetch_valid), .perf_fetched(perf_fetched),
    .perf_wait(perf_wait)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(w_stall), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata), .pc_plus4_out(w_pc4),
    .instr_out(w_instr), .fetch_valid(w_valid), .perf_fetched(w_perf_fetched),
    .perf_wait(w_perf_wait)
  );

`ifdef IF_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_fetched = 0;
  int   exp_wait = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [31:0] data, input logic st,
                       input logic rv, input logic [31:0] rpc);
    imem_ready     = rdy;
    imem_rdata     = data;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  function automatic exp_t pop_exp();
    if (sb.size() == 0) return '0;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    w_ready = 1'b0;
    w_rdata = 32'h0;
    repeat (2) step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req got=%b exp=0", imem_req);
    end
    checks++;
    if (instr_out !== 32'h0 || pc_plus4_out !== 32'h0 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL rst_outs got=%h/%h/%b exp=0/0/0", instr_out, pc_plus4_out, fetch_valid);
    end
    checks++;
    if (perf_fetched !== 32'h0 || perf_wait !== 32'h0) begin
      errors++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_fetched, perf_wait);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_release got=%b/%h exp=1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] words [4];
    exp_t e;
    words[0] = 32'h2008_0005;
    words[1] = 32'h2009_0007;
    words[2] = 32'h1111_1111;
    words[3] = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_addr !== 32'(i * 4)) begin
        errors++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, 32'(i * 4));
      end
      drive(1'b1, words[i], 1'b0, 1'b0, 32'h0);
      sb.push_back('{pc4: 32'(i * 4 + 4), instr: words[i]});
      step();
      e = pop_exp();
      exp_fetched++;
      checks++;
      if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr) begin
        errors++; $display("FAIL seq_out got=%b/%h/%h exp=1/%h/%h", fetch_valid, pc_plus4_out, instr_out, e.pc4, e.instr);
      end
    end
    checks++;
    if (imem_addr !== 32'h10) begin
      errors++; $display("FAIL seq_end_addr got=%h exp=00000010", imem_addr);
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_wait++;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_out !== 32'h0 || fetch_valid !== 1'b0) begin
        errors++; $display("FAIL wait_cycle%0d got=%b/%h/%h/%b exp=1/00000010/0/0", i, imem_req, imem_addr, instr_out, fetch_valid);
      end
    end
    checks++;
    if (perf_wait !== (PERF ? 32'(exp_wait) : 32'h0)) begin
      errors++; $display("FAIL perf_wait got=%0d exp=%0d", perf_wait, PERF ? exp_wait : 0);
    end
    checks++;
    if (perf_fetched !== (PERF ? 32'(exp_fetched) : 32'h0)) begin
      errors++; $display("FAIL perf_fetched got=%0d exp=%0d", perf_fetched, PERF ? exp_fetched : 0);
    end
    drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    sb.push_back('{pc4: 32'h14, instr: 32'h3333_3333});
    step();
    e = pop_exp();
    exp_fetched++;
    checks++;
    if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr) begin
      errors++; $display("FAIL wait_deliver got=%b/%h/%h exp=1/%h/%h", fetch_valid, pc_plus4_out, instr_out, e.pc4, e.instr);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    for (int a = 32'h14; a <= 32'h1C; a += 4) begin
      drive(1'b1, 32'hB000_0000 | 32'(a), 1'b0, 1'b0, 32'h0);
      sb.push_back('{pc4: 32'(a + 4), instr: 32'hB000_0000 | 32'(a)});
      step();
      e = pop_exp();
      exp_fetched++;
      checks++;
      if (pc_plus4_out !== e.pc4 || instr_out !== e.instr) begin
        errors++; $display("FAIL stall_pre got=%h/%h exp=%h/%h", pc_plus4_out, instr_out, e.pc4, e.instr);
      end
    end
    drive(1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0);
    sb.push_back('{pc4: 32'h24, instr: 32'h4444_4444});
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b0 || fetch_valid !== 1'b1 || pc_plus4_out !== 32'h20 || instr_out !== 32'hB000_001C) begin
        errors++; $display("FAIL stall_frozen%0d got=%b/%b/%h/%h exp=0/1/00000020/b000001c", i, imem_req, fetch_valid, pc_plus4_out, instr_out);
      end
    end
    drive(1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0);
    step();
    e = pop_exp();
    exp_fetched++;
    checks++;
    if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr || imem_addr !== 32'h24) begin
      errors++; $display("FAIL stall_release got=%b/%h/%h/%h exp=1/%h/%h/00000024", fetch_valid, pc_plus4_out, instr_out, imem_addr, e.pc4, e.instr);
    end
  endtask

  task automatic test_redirect_drain();
    exp_t e;
    for (int a = 32'h24; a <= 32'h3C; a += 4) begin
      drive(1'b1, 32'hA000_0000 | 32'(a), 1'b0, 1'b0, 32'h0);
      sb.push_back('{pc4: 32'(a + 4), instr: 32'hA000_0000 | 32'(a)});
      step();
      e = pop_exp();
      exp_fetched++;
      checks++;
      if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr) begin
        errors++; $display("FAIL drain_pre got=%b/%h/%h exp=1/%h/%h", fetch_valid, pc_plus4_out, instr_out, e.pc4, e.instr);
      end
    end
    drive(1'b0, 32'hBAD0_0000, 1'b0, 1'b1, 32'h103);
    step();
    exp_wait++;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || fetch_valid !== 1'b0 || instr_out !== 32'h0) begin
      errors++; $display("FAIL drain_hold1 got=%b/%h/%b/%h exp=1/00000040/0/0", imem_req, imem_addr, fetch_valid, instr_out);
    end
    drive(1'b0, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
    step();
    exp_wait++;
    checks++;
    if (imem_addr !== 32'h40 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL drain_hold2 got=%h/%b exp=00000040/0", imem_addr, fetch_valid);
    end
    drive(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (fetch_valid !== 1'b0 || instr_out !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL drain_done got=%b/%h/%b/%h exp=0/0/1/00000100", fetch_valid, instr_out, imem_req, imem_addr);
    end
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
    sb.push_back('{pc4: 32'h104, instr: 32'h5555_5555});
    step();
    e = pop_exp();
    exp_fetched++;
    checks++;
    if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr) begin
      errors++; $display("FAIL drain_target got=%b/%h/%h exp=1/%h/%h", fetch_valid, pc_plus4_out, instr_out, e.pc4, e.instr);
    end
  endtask

  task automatic test_redirect_stall();
    exp_t e;
    drive(1'b1, 32'h6666_6666, 1'b1, 1'b1, 32'h200);
    step();
    checks++;
    if (fetch_valid !== 1'b0 || instr_out !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL rs_bubble got=%b/%h/%b/%h exp=0/0/1/00000200", fetch_valid, instr_out, imem_req, imem_addr);
    end
    drive(1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
    sb.push_back('{pc4: 32'h204, instr: 32'h7777_7777});
    step();
    e = pop_exp();
    exp_fetched++;
    checks++;
    if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr) begin
      errors++; $display("FAIL rs_after got=%b/%h/%h exp=1/%h/%h", fetch_valid, pc_plus4_out, instr_out, e.pc4, e.instr);
    end
    drive(1'b1, 32'h8888_8888, 1'b1, 1'b0, 32'h0);
    step();
    checks++;
    if (imem_req !== 1'b0 || pc_plus4_out !== 32'h204 || instr_out !== 32'h7777_7777) begin
      errors++; $display("FAIL rs_hold got=%b/%h/%h exp=0/00000204/77777777", imem_req, pc_plus4_out, instr_out);
    end
    drive(1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'h302);
    step();
    checks++;
    if (fetch_valid !== 1'b0 || instr_out !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++; $display("FAIL rs_hold_redirect got=%b/%h/%b/%h exp=0/0/1/00000300", fetch_valid, instr_out, imem_req, imem_addr);
    end
    drive(1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h0);
    sb.push_back('{pc4: 32'h304, instr: 32'h9999_9999});
    step();
    e = pop_exp();
    exp_fetched++;
    checks++;
    if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr) begin
      errors++; $display("FAIL rs_target got=%b/%h/%h exp=1/%h/%h", fetch_valid, pc_plus4_out, instr_out, e.pc4, e.instr);
    end
  endtask

  task automatic test_wrap();
    // Main instance idles stalled with a live request outstanding.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", w_req, w_addr);
    end
    w_ready = 1'b1;
    w_rdata = 32'hCAFE_0001;
    step();
    exp_wait++;
    checks++;
    if (w_valid !== 1'b1 || w_pc4 !== 32'h0 || w_instr !== 32'hCAFE_0001 || w_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_second got=%b/%h/%h/%h exp=1/0/cafe0001/0", w_valid, w_pc4, w_instr, w_addr);
    end
    w_rdata = 32'hCAFE_0002;
    step();
    exp_wait++;
    checks++;
    if (w_pc4 !== 32'h4 || w_addr !== 32'h4) begin
      errors++; $display("FAIL wrap_third got=%h/%h exp=4/4", w_pc4, w_addr);
    end
    w_ready = 1'b0;
    checks++;
    if (fetch_valid !== 1'b1 || pc_plus4_out !== 32'h304 || instr_out !== 32'h9999_9999 || imem_addr !== 32'h304) begin
      errors++; $display("FAIL stall_nodone got=%b/%h/%h/%h exp=1/00000304/99999999/00000304", fetch_valid, pc_plus4_out, instr_out, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h7C);
    step();
    drive(1'b1, 32'h7777_0000, 1'b0, 1'b0, 32'h0);
    sb.push_back('{pc4: 32'h80, instr: 32'h7777_0000});
    step();
    e = pop_exp();
    exp_fetched++;
    checks++;
    if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr || imem_addr !== 32'h80) begin
      errors++; $display("FAIL rm_pre got=%b/%h/%h/%h exp=1/%h/%h/00000080", fetch_valid, pc_plus4_out, instr_out, imem_addr, e.pc4, e.instr);
    end
    drive(1'b0, 32'hBAD, 1'b0, 1'b0, 32'h0);
    step();
    exp_wait++;
    checks++;
    if (perf_fetched !== (PERF ? 32'(exp_fetched) : 32'h0) || perf_wait !== (PERF ? 32'(exp_wait) : 32'h0)) begin
      errors++; $display("FAIL rm_perf got=%0d/%0d exp=%0d/%0d", perf_fetched, perf_wait, PERF ? exp_fetched : 0, PERF ? exp_wait : 0);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc_plus4_out !== 32'h0 || instr_out !== 32'h0 || fetch_valid !== 1'b0 ||
        perf_fetched !== 32'h0 || perf_wait !== 32'h0) begin
      errors++; $display("FAIL rm_async got=%b/%h/%h/%b/%0d/%0d exp=0/0/0/0/0/0", imem_req, pc_plus4_out, instr_out, fetch_valid, perf_fetched, perf_wait);
    end
    step();
    reset = 1'b0;
    drive(1'b1, 32'hC0DE_0001, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rm_release got=%b/%h exp=1/00000000", imem_req, imem_addr);
    end
    sb.push_back('{pc4: 32'h4, instr: 32'hC0DE_0001});
    step();
    e = pop_exp();
    checks++;
    if (fetch_valid !== 1'b1 || pc_plus4_out !== e.pc4 || instr_out !== e.instr ||
        perf_fetched !== (PERF ? 32'h1 : 32'h0) || perf_wait !== 32'h0) begin
      errors++; $display("FAIL rm_first got=%b/%h/%h/%0d/%0d exp=1/%h/%h/%0d/0", fetch_valid, pc_plus4_out, instr_out, perf_fetched, perf_wait, e.pc4, e.instr, PERF ? 1 : 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall();
    test_redirect_drain();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard-unit hold; freezes PC and outputs.
REQ-005 redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 redirect_pc  input  32  new fetch target; bits [1:0] ignored, treated as 0.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_ready  input  1  memory completes request this cycle.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-011 pc_plus4_out  output  32  fetched PC + 4, to if_id pc_plus4_in.
REQ-012 instr_out  output  32  fetched instruction, to if_id instr_in; 32'h0 is a bubble.
REQ-013 fetch_valid  output  1  instr_out holds a real instruction.
REQ-014 perf_fetched  output  32  delivered-instruction count (see Configuration).
REQ-015 perf_wait  output  32  memory wait-cycle count (see Configuration).

Function
REQ-016 States: FETCH (request live), HOLD (word buffered under stall), DRAIN (discarding a stale outstanding request).
REQ-017 imem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD and during reset; imem_addr SHALL be the address of the live request and stay stable while imem_req && !imem_ready.
REQ-018 Completion SHALL be imem_req && imem_ready in one cycle; zero-wait memory SHALL sustain one instruction per cycle.
REQ-019 FETCH, completion, no stall, no redirect: next edge instr_out<=imem_rdata, pc_plus4_out<=pc+4, fetch_valid<=1, pc<=pc+4, stay FETCH.
REQ-020 FETCH, no completion, no stall, no redirect: next edge instr_out<=0, fetch_valid<=0, pc_plus4_out held, pc held.
REQ-021 stall=1 (no redirect): instr_out, pc_plus4_out, fetch_valid, pc SHALL hold.
REQ-022 FETCH, completion with stall=1: word captured in a hold buffer, go HOLD.
REQ-023 HOLD, stall=0: outputs<=buffer with pc_plus4_out=pc+4, fetch_valid<=1, pc<=pc+4, go FETCH; HOLD, stall=1: remain.
REQ-024 redirect_valid SHALL take priority over stall: pc<={redirect_pc[31:2],2'b00}, instr_out<=0, fetch_valid<=0, hold buffer discarded.
REQ-025 Redirect in FETCH with completion same cycle, or in HOLD: fetched word discarded, go FETCH.
REQ-026 Redirect in FETCH without completion: go DRAIN; DRAIN keeps old address until completion, discards data, then goes FETCH at redirected pc.
REQ-027 Redirect during DRAIN: pc updated to newest target, stay DRAIN (or go FETCH if completion same cycle).
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-029 While reset=1: pc=RESET_PC, state=FETCH, imem_req=0, instr_out=0, pc_plus4_out=0, fetch_valid=0, hold buffer=0, counters=0.
REQ-030 Reset asserted mid-request SHALL abandon the transfer immediately; first cycle after release issues imem_addr=RESET_PC.

Configuration
REQ-031 Macro IF_PERF_EN defined: perf_fetched increments on every edge that sets fetch_valid with a new instruction; perf_wait increments each cycle imem_req && !imem_ready; both wrap at 2^32.
REQ-032 IF_PERF_EN undefined: no counter flops; perf_fetched and perf_wait tied to 32'h0.

Verification
REQ-033 Reset release, imem_ready=1, rdata=32'h2008_0005 then 32'h2009_0007 -> imem_addr 0,4,8; outputs (4,20080005),(8,20090007), fetch_valid=1 each cycle.
REQ-034 imem_ready low 3 cycles at addr 32'h10 -> addr stable 3 cycles, instr_out=0, fetch_valid=0, perf_wait=3 (IF_PERF_EN), then word delivered with pc_plus4_out=32'h14.
REQ-035 stall=1 two cycles while word at 32'h20 completes -> outputs frozen, imem_req=0 second cycle; stall drop -> pc_plus4_out=32'h24 next edge.
REQ-036 redirect_valid with redirect_pc=32'h103 during 2-cycle wait at 32'h40 -> DRAIN holds addr 32'h40, stale data dropped, next request addr 32'h100.
REQ-037 redirect and stall together -> bubble (fetch_valid=0), pc=target; RESET_PC=32'hFFFF_FFFC -> second fetch addr 32'h0.
REQ-038 reset mid-wait at addr 32'h80 -> outputs zero asynchronously, first post-reset imem_addr=RESET_PC, counters 0.
